// File: rtl/divider_bus_system_if.sv
// Byte-serial host bus for the 16-bit divider: operand bytes in, result bytes out.
// The host holds the master modport; the divider holds the slave modport.
interface divider_bus_system_if;
    logic       dataready;
    logic [7:0] Data_in;
    logic       receiveData;
    logic [7:0] Data_out;
    logic       OutBuffFull;
    logic       error;
    logic       readyToAccept;

    modport master (
        output dataready,
        output Data_in,
        output receiveData,
        input  Data_out,
        input  OutBuffFull,
        input  error,
        input  readyToAccept
    );

    modport slave (
        input  dataready,
        input  Data_in,
        input  receiveData,
        output Data_out,
        output OutBuffFull,
        output error,
        output readyToAccept
    );
endinterface

// File: rtl/divider_bus_system.sv
// 16-bit unsigned restoring divider. Operands arrive as four bytes, LSB first;
// quotient and remainder leave as four bytes. Each quotient bit takes one clock.
module divider_bus_system (
    input  logic                  clk,
    input  logic                  rst,
    divider_bus_system_if.slave   bus
);
    typedef enum logic [1:0] {IN_WAIT, IN_ACK, CALC, OUT} state_t;

    state_t      state_reg;
    logic [2:0]  cnt_reg;
    logic [1:0]  ptr_reg;
    logic [3:0]  iter_reg;
    logic [7:0]  in_slot_reg [4];
    logic [7:0]  out_buf_reg [4];
    logic [15:0] a_reg;
    logic [15:0] q_reg;
    logic [7:0]  data_out_reg;
    logic        out_full_reg;
    logic        error_reg;
    logic        ack_reg;

    logic [15:0] divisor;
    logic [16:0] shifted;
    logic [16:0] diff;
    logic [15:0] a_next;
    logic [15:0] q_next;

    assign divisor = {in_slot_reg[3], in_slot_reg[2]};

    // The partial remainder stays below the divisor, so after restoring it fits in 16 bits;
    // only the shifted value needs the 17th bit to form the trial subtraction.
    assign shifted = {a_reg, q_reg[15]};
    assign diff    = shifted - {1'b0, divisor};
    assign a_next  = diff[16] ? shifted[15:0] : diff[15:0];
    assign q_next  = {q_reg[14:0], ~diff[16]};

    assign bus.Data_out      = data_out_reg;
    assign bus.OutBuffFull   = out_full_reg;
    assign bus.error         = error_reg;
    assign bus.readyToAccept = ack_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IN_WAIT;
            cnt_reg      <= 3'd0;
            ptr_reg      <= 2'd0;
            iter_reg     <= 4'd0;
            a_reg        <= 16'd0;
            q_reg        <= 16'd0;
            data_out_reg <= 8'd0;
            out_full_reg <= 1'b0;
            error_reg    <= 1'b0;
            ack_reg      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                in_slot_reg[i] <= 8'd0;
                out_buf_reg[i] <= 8'd0;
            end
        end else begin
            case (state_reg)
                IN_WAIT: begin
                    if (bus.dataready) begin
                        in_slot_reg[cnt_reg[1:0]] <= bus.Data_in;
                        error_reg                 <= 1'b0;
                        ack_reg                   <= 1'b1;
                        state_reg                 <= IN_ACK;
                    end
                end

                IN_ACK: begin
                    if (!bus.dataready) begin
                        ack_reg <= 1'b0;
                        cnt_reg <= cnt_reg + 3'd1;
                        if (cnt_reg == 3'd3) begin
                            a_reg     <= 16'd0;
                            q_reg     <= {in_slot_reg[1], in_slot_reg[0]};
                            iter_reg  <= 4'd0;
                            state_reg <= CALC;
                        end else begin
                            state_reg <= IN_WAIT;
                        end
                    end
                end

                CALC: begin
                    if (divisor == 16'd0) begin
                        error_reg <= 1'b1;
                        cnt_reg   <= 3'd0;
                        state_reg <= IN_WAIT;
                    end else begin
                        a_reg    <= a_next;
                        q_reg    <= q_next;
                        iter_reg <= iter_reg + 4'd1;
                        // Final iteration: the buffer is loaded straight from the next-state values.
                        if (iter_reg == 4'd15) begin
                            out_buf_reg[0] <= q_next[7:0];
                            out_buf_reg[1] <= q_next[15:8];
                            out_buf_reg[2] <= a_next[7:0];
                            out_buf_reg[3] <= a_next[15:8];
                            data_out_reg   <= q_next[7:0];
                            out_full_reg   <= 1'b1;
                            ptr_reg        <= 2'd0;
                            state_reg      <= OUT;
                        end
                    end
                end

                OUT: begin
                    if (bus.receiveData) begin
                        if (ptr_reg == 2'd3) begin
                            out_full_reg <= 1'b0;
                            data_out_reg <= 8'd0;
                            ptr_reg      <= 2'd0;
                            cnt_reg      <= 3'd0;
                            state_reg    <= IN_WAIT;
                        end else begin
                            data_out_reg <= out_buf_reg[ptr_reg + 2'd1];
                            ptr_reg      <= ptr_reg + 2'd1;
                        end
                    end
                end

                default: state_reg <= IN_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_divider_bus_system.sv
// Scoreboard bench for divider_bus_system: expected result bytes are queued when
// operands are driven and compared as the host pops them from the output buffer.
module tb_divider_bus_system;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    divider_bus_system_if bus ();

    divider_bus_system dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        int n;
        bus.Data_in   = b;
        bus.dataready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.readyToAccept && n < 10);
        check("ack_rise", {31'd0, bus.readyToAccept}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("ack_hold", {31'd0, bus.readyToAccept}, 32'd1);
        end
        bus.dataready = 1'b0;
        tick();
        check("ack_fall", {31'd0, bus.readyToAccept}, 32'd0);
    endtask

    task automatic send_operands(input logic [15:0] dvd, input logic [15:0] dvs, input int hold);
        logic [15:0] q;
        logic [15:0] r;
        if (dvs != 16'd0) begin
            q = dvd / dvs;
            r = dvd % dvs;
            exp_q.push_back(q[7:0]);
            exp_q.push_back(q[15:8]);
            exp_q.push_back(r[7:0]);
            exp_q.push_back(r[15:8]);
        end
        $display("send dividend=%04h divisor=%04h hold=%0d", dvd, dvs, hold);
        send_byte(dvd[7:0], hold);
        send_byte(dvd[15:8], hold);
        send_byte(dvs[7:0], hold);
        send_byte(dvs[15:8], hold);
    endtask

    // Optionally pokes dataready during the first cycles of the division to confirm no ack.
    task automatic wait_result(input bit probe);
        int n;
        n = 0;
        while (!bus.OutBuffFull && n < 25) begin
            if (probe && n < 3) begin
                bus.Data_in   = 8'hAA;
                bus.dataready = 1'b1;
            end else begin
                bus.dataready = 1'b0;
            end
            tick();
            n++;
            if (probe && n <= 3)
                check("calc_no_ack", {31'd0, bus.readyToAccept}, 32'd0);
        end
        bus.dataready = 1'b0;
        check("latency_le_19", {31'd0, (n <= 19)}, 32'd1);
        check("out_full_set", {31'd0, bus.OutBuffFull}, 32'd1);
        check("error_clear", {31'd0, bus.error}, 32'd0);
    endtask

    task automatic pop_byte();
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        $display("pop data=%02h expected=%02h", bus.Data_out, e);
        check("pop_data", {24'd0, bus.Data_out}, {24'd0, e});
        bus.receiveData = 1'b1;
        tick();
        bus.receiveData = 1'b0;
    endtask

    task automatic pop_result();
        for (int k = 0; k < 4; k++)
            pop_byte();
        check("out_full_drop", {31'd0, bus.OutBuffFull}, 32'd0);
        check("data_out_zero", {24'd0, bus.Data_out}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"}, {24'd0, bus.Data_out}, 32'd0);
        check({tag, "_out_full"}, {31'd0, bus.OutBuffFull}, 32'd0);
        check({tag, "_error"}, {31'd0, bus.error}, 32'd0);
        check({tag, "_ack"}, {31'd0, bus.readyToAccept}, 32'd0);
    endtask

    task automatic run_div(input logic [15:0] dvd, input logic [15:0] dvs, input int hold, input bit probe);
        send_operands(dvd, dvs, hold);
        wait_result(probe);
        pop_result();
    endtask

    initial begin
        rst             = 1'b0;
        bus.dataready   = 1'b0;
        bus.Data_in     = 8'd0;
        bus.receiveData = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // receiveData must be ignored while the buffer is empty.
        bus.receiveData = 1'b1;
        tick();
        bus.receiveData = 1'b0;
        check("idle_pop_ignored", {31'd0, bus.OutBuffFull}, 32'd0);

        run_div(16'd45, 16'd7, 0, 1'b1);
        run_div(16'h0103, 16'h0102, 0, 1'b0);

        send_operands(16'h0005, 16'h0000, 0);
        tick();
        tick();
        check("div0_error", {31'd0, bus.error}, 32'd1);
        check("div0_no_full", {31'd0, bus.OutBuffFull}, 32'd0);
        run_div(16'd45, 16'd7, 0, 1'b0);

        run_div(16'h1234, 16'h0056, 5, 1'b0);
        run_div(16'hFFFF, 16'h0001, 0, 1'b0);
        run_div(16'h0003, 16'h000A, 0, 1'b0);
        run_div(16'hFFFF, 16'hFFFF, 0, 1'b0);
        for (int t = 0; t < 4; t++)
            run_div(16'($urandom_range(0, 65535)), 16'($urandom_range(1, 65535)), 0, 1'b0);

        // Reset in the middle of the division.
        send_operands(16'd45, 16'd7, 0);
        repeat (5) tick();
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_calc");
        exp_q.delete();
        tick();
        rst = 1'b1;
        tick();

        // Reset while results are being drained.
        send_operands(16'd1000, 16'd3, 0);
        wait_result(1'b0);
        pop_byte();
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_out");
        exp_q.delete();
        tick();
        rst = 1'b1;
        tick();

        run_div(16'd45, 16'd7, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
